// File: rtl/irq_vec_ctrl.sv
// Vectored interrupt controller: edge/level request latching, fixed-priority
// dispatch handshake, in-service tracking with EOI. Define IRQ_VEC_NEST_EN for nested preemption.
module irq_vec_ctrl #(
  parameter int IRQ_CH    = 8,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int VEC_SHIFT = 2,
  parameter int CH_W      = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IRQ_CH-1:0] irq,
  input  logic              creg_wr_en,
  input  logic [2:0]        creg_addr,
  input  logic [DATA_W-1:0] creg_wr_data,
  output logic [DATA_W-1:0] creg_rd_data,
  output logic              int_req,
  output logic [ADDR_W-1:0] int_vector,
  input  logic              int_ack,
  input  logic              exrt,
  output logic              int_active
);

  localparam logic [2:0] A_STATUS  = 3'd0;
  localparam logic [2:0] A_MASK    = 3'd1;
  localparam logic [2:0] A_MODE    = 3'd2;
  localparam logic [2:0] A_PENDING = 3'd3;
  localparam logic [2:0] A_INSVC   = 3'd4;
  localparam logic [2:0] A_VECBASE = 3'd5;
  localparam logic [2:0] A_EOI     = 3'd6;
  localparam logic [2:0] A_CAUSE   = 3'd7;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_REQ  = 1'b1;

  logic              int_en_q, int_en_d;
  logic              pre_int_en_q, pre_int_en_d;
  logic [IRQ_CH-1:0] mask_q, mask_d;
  logic [IRQ_CH-1:0] mode_q, mode_d;
  logic [IRQ_CH-1:0] latch_q, latch_d;
  logic [IRQ_CH-1:0] in_service_q, in_service_d;
  logic [IRQ_CH-1:0] irq_d_q;
  logic [ADDR_W-1:0] vec_base_q, vec_base_d;
  logic              cause_vld_q, cause_vld_d;
  logic [CH_W-1:0]   cause_ch_q, cause_ch_d;
  logic [0:0]        state_q, state_d;
  logic              int_req_q, int_req_d;
  logic [ADDR_W-1:0] int_vector_q, int_vector_d;
  logic [CH_W-1:0]   int_ch_q, int_ch_d;

  function automatic logic [CH_W-1:0] lowest_idx(input logic [IRQ_CH-1:0] v);
    lowest_idx = '0;
    for (int i = IRQ_CH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = CH_W'(i);
    end
  endfunction

  function automatic logic [ADDR_W-1:0] vec_addr(input logic [ADDR_W-1:0] base,
                                                 input logic [CH_W-1:0]   ch);
    vec_addr = base + (ADDR_W'(ch) << VEC_SHIFT);
  endfunction

  logic              wr_status, wr_mask, wr_mode, wr_pend, wr_vbase, wr_eoi;
  logic [IRQ_CH-1:0] wr_bits;
  logic [IRQ_CH-1:0] irq_rise;
  logic [IRQ_CH-1:0] pending;
  logic [IRQ_CH-1:0] is_lowest;
  logic [IRQ_CH-1:0] nest_allow;
  logic [IRQ_CH-1:0] cand;
  logic              cand_any;
  logic [CH_W-1:0]   win_ch;
  logic              ack_fire;
  logic [IRQ_CH-1:0] ack_bit;
  logic [8:0]        cause_word;
  logic              unused_wr_bits;

  assign wr_status = creg_wr_en && (creg_addr == A_STATUS);
  assign wr_mask   = creg_wr_en && (creg_addr == A_MASK);
  assign wr_mode   = creg_wr_en && (creg_addr == A_MODE);
  assign wr_pend   = creg_wr_en && (creg_addr == A_PENDING);
  assign wr_vbase  = creg_wr_en && (creg_addr == A_VECBASE);
  assign wr_eoi    = creg_wr_en && (creg_addr == A_EOI);
  assign wr_bits   = creg_wr_data[IRQ_CH-1:0];
  assign unused_wr_bits = ^creg_wr_data;

  assign irq_rise = irq & ~irq_d_q;
  assign pending  = (mode_q & latch_q) | (~mode_q & irq);

  // Isolated lowest in-service bit; subtracting one yields every strictly lower index
  // (all ones when nothing is in service).
  assign is_lowest = in_service_q & (~in_service_q + IRQ_CH'(1));

`ifdef IRQ_VEC_NEST_EN
  assign nest_allow = is_lowest - IRQ_CH'(1);
`else
  assign nest_allow = (in_service_q == '0) ? '1 : '0;
`endif

  assign cand     = pending & ~mask_q & nest_allow & {IRQ_CH{int_en_q}};
  assign cand_any = |cand;
  assign win_ch   = lowest_idx(cand);

  // Acknowledge always refers to the channel currently presented on int_vector.
  assign ack_fire = (state_q == ST_REQ) && int_ack;
  assign ack_bit  = ack_fire ? (IRQ_CH'(1) << int_ch_q) : '0;

  always_comb begin
    int_en_d     = int_en_q;
    pre_int_en_d = pre_int_en_q;
    mask_d       = wr_mask  ? wr_bits : mask_q;
    mode_d       = wr_mode  ? wr_bits : mode_q;
    vec_base_d   = wr_vbase ? creg_wr_data[ADDR_W-1:0] : vec_base_q;
    latch_d      = (latch_q & ~(wr_pend ? wr_bits : '0) & ~ack_bit) | irq_rise;
    in_service_d = (in_service_q & ~(wr_eoi ? is_lowest : '0)) | ack_bit;
    cause_vld_d  = cause_vld_q;
    cause_ch_d   = cause_ch_q;

    if (ack_fire) begin
      pre_int_en_d = int_en_q;
      int_en_d     = 1'b0;
      cause_vld_d  = 1'b1;
      cause_ch_d   = int_ch_q;
    end else if (wr_status) begin
      int_en_d     = creg_wr_data[0];
      pre_int_en_d = creg_wr_data[1];
    end else if (exrt) begin
      int_en_d     = pre_int_en_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_vector_d = int_vector_q;
    int_ch_d     = int_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (cand_any) begin
          state_d      = ST_REQ;
          int_req_d    = 1'b1;
          int_vector_d = vec_addr(vec_base_q, win_ch);
          int_ch_d     = win_ch;
        end
      end
      default: begin
        if (ack_fire || !cand_any) begin
          state_d   = ST_IDLE;
          int_req_d = 1'b0;
        end else begin
          int_vector_d = vec_addr(vec_base_q, win_ch);
          int_ch_d     = win_ch;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      int_en_q     <= 1'b0;
      pre_int_en_q <= 1'b0;
      mask_q       <= '1;
      mode_q       <= '0;
      latch_q      <= '0;
      in_service_q <= '0;
      irq_d_q      <= '0;
      vec_base_q   <= '0;
      cause_vld_q  <= 1'b0;
      cause_ch_q   <= '0;
      state_q      <= ST_IDLE;
      int_req_q    <= 1'b0;
      int_vector_q <= '0;
      int_ch_q     <= '0;
    end else begin
      int_en_q     <= int_en_d;
      pre_int_en_q <= pre_int_en_d;
      mask_q       <= mask_d;
      mode_q       <= mode_d;
      latch_q      <= latch_d;
      in_service_q <= in_service_d;
      irq_d_q      <= irq;
      vec_base_q   <= vec_base_d;
      cause_vld_q  <= cause_vld_d;
      cause_ch_q   <= cause_ch_d;
      state_q      <= state_d;
      int_req_q    <= int_req_d;
      int_vector_q <= int_vector_d;
      int_ch_q     <= int_ch_d;
    end
  end

  always_comb begin
    cause_word             = '0;
    cause_word[8]          = cause_vld_q;
    cause_word[CH_W-1:0]   = cause_ch_q;
  end

  always_comb begin
    creg_rd_data = '0;
    case (creg_addr)
      A_STATUS:  creg_rd_data = DATA_W'({pre_int_en_q, int_en_q});
      A_MASK:    creg_rd_data = DATA_W'(mask_q);
      A_MODE:    creg_rd_data = DATA_W'(mode_q);
      A_PENDING: creg_rd_data = DATA_W'(pending);
      A_INSVC:   creg_rd_data = DATA_W'(in_service_q);
      A_VECBASE: creg_rd_data = DATA_W'(vec_base_q);
      A_EOI:     creg_rd_data = '0;
      A_CAUSE:   creg_rd_data = DATA_W'(cause_word);
      default:   creg_rd_data = '0;
    endcase
  end

  assign int_req    = int_req_q;
  assign int_vector = int_vector_q;
  assign int_active = |in_service_q;

endmodule

// File: tb/tb_irq_vec_ctrl.sv
// Self-checking bench for irq_vec_ctrl: register table plus hand-written
// dispatch, withdraw, edge-latch, nesting and reset sequences.
module tb_irq_vec_ctrl;

  logic        clk;
  logic        reset;
  logic [7:0]  irq;
  logic        creg_wr_en;
  logic [2:0]  creg_addr;
  logic [31:0] creg_wr_data;
  logic [31:0] creg_rd_data;
  logic        int_req;
  logic [29:0] int_vector;
  logic        int_ack;
  logic        exrt;
  logic        int_active;

  irq_vec_ctrl #(.IRQ_CH(8), .ADDR_W(30), .DATA_W(32), .VEC_SHIFT(2), .CH_W(3)) dut (
    .clk(clk), .reset(reset), .irq(irq),
    .creg_wr_en(creg_wr_en), .creg_addr(creg_addr), .creg_wr_data(creg_wr_data),
    .creg_rd_data(creg_rd_data), .int_req(int_req), .int_vector(int_vector),
    .int_ack(int_ack), .exrt(exrt), .int_active(int_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_push(input string name, input logic [31:0] exp);
    sb_q.push_back('{name, exp});
  endtask

  task automatic sb_pop_cmp(input logic [31:0] act);
    sb_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] exp, input logic [31:0] act);
    sb_push(name, exp);
    sb_pop_cmp(act);
  endtask

  task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string name);
    sb_push(name, exp);
    creg_addr = addr;
    #1;
    sb_pop_cmp(creg_rd_data);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [31:0] data);
    creg_wr_en   = 1'b1;
    creg_addr    = addr;
    creg_wr_data = data;
    tick();
    creg_wr_en   = 1'b0;
  endtask

  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  vec_t tbl[8];

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int req_seen;
    reset = 1'b0; irq = '0; creg_wr_en = 1'b0; creg_addr = '0; creg_wr_data = '0;
    int_ack = 1'b0; exrt = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_int_req", 32'd0, 32'(int_req));
    rd(3'd0, 32'h0, "rst_status");
    rd(3'd1, 32'hFF, "rst_mask");
    reset = 1'b1;
    tick();
    irq = 8'hFF;
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (int_req) req_seen++;
    end
    chk("no_req_after_reset", 32'd0, 32'(req_seen));
    irq = 8'h00;
    tick();
    wr(3'd3, 32'hFF);

    // Register table
    tbl[0] = '{1'b1, 3'd1, 32'hA5,       32'h0,        "wr_mask"};
    tbl[1] = '{1'b0, 3'd1, 32'h0,        32'hA5,       "rd_mask"};
    tbl[2] = '{1'b1, 3'd2, 32'h3C,       32'h0,        "wr_mode"};
    tbl[3] = '{1'b0, 3'd2, 32'h0,        32'h3C,       "rd_mode"};
    tbl[4] = '{1'b1, 3'd5, 32'hFFFFFFFF, 32'h0,        "wr_vbase"};
    tbl[5] = '{1'b0, 3'd5, 32'h0,        32'h3FFFFFFF, "rd_vbase_trunc"};
    tbl[6] = '{1'b0, 3'd6, 32'h0,        32'h0,        "rd_eoi_zero"};
    tbl[7] = '{1'b0, 3'd7, 32'h0,        32'h0,        "rd_cause_rst"};
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].wr) wr(tbl[i].addr, tbl[i].data);
      else rd(tbl[i].addr, tbl[i].exp, tbl[i].name);
    end
    wr(3'd0, 32'h2);
    rd(3'd0, 32'h2, "rd_status_pre");
    wr(3'd2, 32'h0);

    // Level dispatch and EOI
    wr(3'd1, 32'hF7);
    wr(3'd5, 32'h100);
    wr(3'd0, 32'h1);
    irq = 8'h08;
    #1;
    chk("lvl_req_before", 32'd0, 32'(int_req));
    tick();
    chk("lvl_req", 32'd1, 32'(int_req));
    chk("lvl_vec", 32'h10C, 32'(int_vector));
    ack();
    chk("lvl_req_drop", 32'd0, 32'(int_req));
    rd(3'd4, 32'h08, "lvl_insvc");
    rd(3'd7, 32'h103, "lvl_cause");
    rd(3'd0, 32'h2, "lvl_status");
    chk("lvl_active", 32'd1, 32'(int_active));
    wr(3'd6, 32'h0);
    rd(3'd4, 32'h00, "lvl_eoi");
    chk("lvl_inactive", 32'd0, 32'(int_active));
    irq = 8'h00;

    // Edge latch
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h01);
    wr(3'd1, 32'hFE);
    irq = 8'h01; tick(); irq = 8'h00; tick();
    rd(3'd3, 32'h01, "edge_pending");
    chk("edge_no_req_disabled", 32'd0, 32'(int_req));
    wr(3'd0, 32'h1);
    tick();
    chk("edge_req", 32'd1, 32'(int_req));
    chk("edge_vec", 32'h100, 32'(int_vector));
    ack();
    rd(3'd3, 32'h00, "edge_pending_clr");
    rd(3'd4, 32'h01, "edge_insvc");
    wr(3'd6, 32'h0);

    // Priority, withdraw, ack in IDLE
    wr(3'd2, 32'h00);
    wr(3'd1, 32'h00);
    wr(3'd0, 32'h1);
    irq = 8'h24;
    tick();
    chk("prio_req", 32'd1, 32'(int_req));
    chk("prio_vec_ch2", 32'h108, 32'(int_vector));
    irq = 8'h20;
    tick();
    chk("prio_req_hold", 32'd1, 32'(int_req));
    chk("prio_vec_ch5", 32'h114, 32'(int_vector));
    irq = 8'h00;
    tick();
    chk("withdraw_req", 32'd0, 32'(int_req));
    tick();
    chk("withdraw_idle", 32'd0, 32'(int_req));
    rd(3'd4, 32'h00, "withdraw_insvc");
    rd(3'd0, 32'h1, "withdraw_status");
    ack();
    rd(3'd4, 32'h00, "idle_ack_insvc");
    rd(3'd0, 32'h1, "idle_ack_status");

    // Nesting
    irq = 8'h10;
    tick();
    chk("nest_ch4_vec", 32'h110, 32'(int_vector));
    ack();
    irq = 8'h00;
    wr(3'd0, 32'h1);
    irq = 8'h02;
    tick();
`ifdef IRQ_VEC_NEST_EN
    chk("nest_req", 32'd1, 32'(int_req));
    chk("nest_vec", 32'h104, 32'(int_vector));
    ack();
    irq = 8'h00;
    rd(3'd4, 32'h12, "nest_insvc");
    rd(3'd7, 32'h101, "nest_cause");
    wr(3'd0, 32'h1);
    irq = 8'h40;
    tick(); tick();
    chk("nest_low_prio_blocked", 32'd0, 32'(int_req));
    irq = 8'h00;
    wr(3'd6, 32'h0);
    rd(3'd4, 32'h10, "nest_eoi1");
    wr(3'd6, 32'h0);
`else
    chk("nonest_blocked", 32'd0, 32'(int_req));
    tick();
    chk("nonest_blocked2", 32'd0, 32'(int_req));
    wr(3'd6, 32'h0);
    chk("nonest_after_eoi_edge", 32'd0, 32'(int_req));
    tick();
    chk("nonest_req_after_eoi", 32'd1, 32'(int_req));
    chk("nonest_vec", 32'h104, 32'(int_vector));
    ack();
    irq = 8'h00;
    rd(3'd4, 32'h02, "nonest_insvc");
    wr(3'd6, 32'h0);
`endif
    rd(3'd4, 32'h00, "nest_clean");

    // Edge corner: W1C vs new edge, exrt, ack vs STATUS write
    wr(3'd0, 32'h0);
    wr(3'd2, 32'h01);
    wr(3'd1, 32'hFE);
    irq = 8'h01; tick(); irq = 8'h00; tick();
    irq = 8'h01;
    wr(3'd3, 32'h01);
    irq = 8'h00;
    rd(3'd3, 32'h01, "w1c_set_wins");
    wr(3'd3, 32'h01);
    rd(3'd3, 32'h00, "w1c_clears");
    wr(3'd0, 32'h1);
    irq = 8'h01;
    tick();
    chk("edge_latency_n1", 32'd0, 32'(int_req));
    irq = 8'h00;
    tick();
    chk("edge_latency_n2", 32'd1, 32'(int_req));
    ack();
    rd(3'd0, 32'h2, "exrt_before");
    exrt = 1'b1; tick(); exrt = 1'b0;
    rd(3'd0, 32'h3, "exrt_restore");
    wr(3'd6, 32'h0);
    irq = 8'h01; tick(); irq = 8'h00; tick();
    chk("ack_vs_wr_req", 32'd1, 32'(int_req));
    int_ack = 1'b1;
    wr(3'd0, 32'h1);
    int_ack = 1'b0;
    rd(3'd0, 32'h2, "ack_beats_status_wr");
    wr(3'd6, 32'h0);

    // Reset asserted mid-REQ
    wr(3'd0, 32'h1);
    irq = 8'h01; tick(); irq = 8'h00; tick();
    chk("midreq_req", 32'd1, 32'(int_req));
    #2 reset = 1'b0;
    #1;
    chk("midreq_reset_req", 32'd0, 32'(int_req));
    rd(3'd0, 32'h0, "midreq_reset_status");
    rd(3'd1, 32'hFF, "midreq_reset_mask");
    tick();
    reset = 1'b1;
    tick();

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: %0d entries remain, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_vec_ctrl.md
Name: irq_vec_ctrl

Overview:
Parametrised vectored interrupt controller; successor to the fixed 1-bit-enable/mask interrupt logic in the CPU control unit.
- Latches per-channel requests in edge or level mode and selects the winner by fixed priority (lowest index wins).
- Runs a request/acknowledge handshake with the pipeline flush logic and supplies a per-channel vector address.
- Tracks in-service channels until software writes end-of-interrupt (EOI).
- Sits beside the control unit and shares its control-register read/write port semantics.

Parameters:
IRQ_CH, 8, number of interrupt channels (1..32)
ADDR_W, 30, word-address width of vector and PC
DATA_W, 32, register data width
VEC_SHIFT, 2, vector = vec_base + (channel << VEC_SHIFT)
CH_W, 3, channel index width, ceil(log2(IRQ_CH)), minimum 1

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-low reset
irq  in  IRQ_CH  raw interrupt requests, synchronous to clk
creg_wr_en  in  1  register write strobe
creg_addr  in  3  register address, shared by read and write
creg_wr_data  in  DATA_W  write data
creg_rd_data  out  DATA_W  combinational read data
int_req  out  1  interrupt dispatch request (registered)
int_vector  out  ADDR_W  vector word address, valid while int_req=1
int_ack  in  1  pipeline accepted dispatch (flush issued)
exrt  in  1  exception-return retire pulse
int_active  out  1  OR of in-service bits

Behaviour:
- Reset: all regs cleared. int_en=0, mask all-1, mode all-0 (level), pending=0, in_service=0, vec_base=0, cause=0, FSM=IDLE, int_req=0, irq_d=0.
- Register map (addr: read / write):
  - 0 STATUS: {pre_int_en, int_en} in bits [1:0].
  - 1 MASK: 1 = channel masked.
  - 2 MODE: 1 = edge, 0 = level.
  - 3 PENDING: read effective pending; write-1-to-clear edge latches.
  - 4 IN_SERVICE: read-only.
  - 5 VEC_BASE: low ADDR_W bits.
  - 6 EOI: any write clears the lowest-index set in-service bit; read returns 0.
  - 7 CAUSE: {valid@bit8, channel@[CH_W-1:0]}, read-only.
- Edge latch: set on irq & ~irq_d. Set wins over a same-cycle W1C.
- Effective pending: edge ? latch : irq.
- Candidate: pending & ~mask, gated by int_en and the nesting rule. Winner = lowest set index.
- FSM IDLE: when a candidate exists, go to REQ next cycle. int_req=1 and int_vector are registered from the winner.
- Latency: a level irq high at cycle N gives int_req at N+1. An edge at N latches at N+1, so int_req is at N+2.
- FSM REQ: int_req held. int_vector updates if a higher-priority candidate appears before ack.
  - No candidate remains (withdrawn): int_req drops next cycle, back to IDLE, no state change.
  - int_ack=1: set in_service[ch], clear edge latch[ch], pre_int_en<=int_en, int_en<=0, cause<={1, ch}, return to IDLE with int_req=0 next cycle.
- int_ack while IDLE: ignored.
- exrt: int_en<=pre_int_en.
- Same-cycle priorities:
  - int_ack beats a STATUS write and exrt.
  - EOI write applies before the nesting evaluation of the next cycle.
- vector = vec_base + (ch << VEC_SHIFT), truncated to ADDR_W.
- Reset asserted mid-REQ: immediate IDLE, int_req=0.

Optional Feature:
IRQ_VEC_NEST_EN.
- Defined: a candidate qualifies only if its index is lower than the lowest in-service index, which allows nested preemption. in_service may hold multiple bits.
- Undefined: no dispatch while in_service != 0. At most one bit is ever set.

Test Plan:
- Reset: int_en=0, MASK reads 0xFF, int_req=0. After releasing reset, irq=0xFF for 10 cycles -> int_req stays 0.
- Level dispatch and EOI:
  - Setup: MASK=0xF7, int_en=1, VEC_BASE=0x100.
  - Raise irq[3] at cycle N -> int_req=1 at N+1, int_vector=0x10C.
  - Ack -> IN_SERVICE=0x08, CAUSE=0x103, int_en=0.
  - Write EOI -> IN_SERVICE=0.
- Edge latch: MODE=0x01, MASK=0xFE, int_en=0. Pulse irq[0] for 1 cycle -> PENDING=0x01. Set int_en=1 -> int_req. Ack -> PENDING=0.
- Priority and withdraw: irq[5] and irq[2] level together -> int_vector selects ch2. Drop irq[2] before ack -> vector switches to ch5. Drop irq[5] -> int_req falls, IDLE.
- Nesting:
  - With IRQ_VEC_NEST_EN: ch4 in service, int_en=1, raise irq[1] -> dispatch ch1, IN_SERVICE=0x12. Raise irq[6] instead -> no req.
  - Without the macro: irq[1] gets no req until EOI.
- Edge corner: W1C of PENDING[0] in the same cycle as a new edge on irq[0] -> PENDING stays 1. exrt after ack restores int_en=1.
